pe_mem_bridge: RTL
==================

Name: pe_mem_bridge

Overview:
- Responder side of the pe_con BRAM port: owns a word memory, answers pe_con BRAM reads/writes, and sequences a complete job around the controller.
- Host-side valid/ready stream loads the operand image from word 0; the bridge then pulses start to pe_con and serves its BRAM traffic until done.
- It then streams the result region back to the host.
- Synthesizable replacement for the bench memory model in system-level runs.

Parameters:
MEM_AW, 10, log2 of memory depth in 32-bit words (depth = 2^MEM_AW)
RES_BASE, 0, first word index of the result region dumped after done
RES_LEN, 64, number of words dumped (1..2^MEM_AW)

Ports:
aclk  input  1  sole clock; memory, FSM and BRAM port all on this clock
aresetn  input  1  asynchronous active-low reset
start  output  1  one-cycle job-start pulse to pe_con
done  input  1  job-complete level from pe_con
BRAM_ADDR  input  32  byte address from pe_con; word index = BRAM_ADDR[MEM_AW+1:2]
BRAM_WRDATA  input  32  write data
BRAM_WE  input  4  byte write enables, bit i -> byte i
BRAM_EN  input  1  port enable
BRAM_RDDATA  output  32  registered read data
s_valid  input  1  load stream valid
s_ready  output  1  load stream ready
s_data  input  32  load word
s_last  input  1  final load word
m_valid  output  1  dump stream valid
m_ready  input  1  dump stream ready
m_data  output  32  dump word
m_last  output  1  final dump word
busy  output  1  high in any state except IDLE
err  output  1  sticky load-overflow flag, cleared only by reset

Behaviour:
- Reset (async assert, sync release): state IDLE; start, s_ready, m_valid, m_last, busy, err = 0; m_data, BRAM_RDDATA = 0; load pointer = 0. Memory contents are not cleared.
- States: IDLE, LOAD, START, RUN, DUMP.
- IDLE:
  - s_ready = 1.
  - A beat (s_valid & s_ready) writes s_data to word 0, sets pointer = 1, and moves to LOAD.
  - If that beat also has s_last, go directly to START.
- LOAD:
  - s_ready = 1; each beat writes mem[pointer] and increments pointer.
  - The beat with s_last -> START.
  - Overflow: a beat arriving when pointer = 2^MEM_AW is accepted, dropped, and sets err.
- START: start = 1 for exactly this one cycle; s_ready = 0; next state RUN.
- RUN:
  - BRAM port active. With BRAM_EN = 1, the word at the addressed index is latched into BRAM_RDDATA at the next edge (1-cycle read latency). The old word is returned on read-during-write.
  - Writes update only the bytes enabled by BRAM_WE in the same edge.
  - Address bits above MEM_AW+1 are ignored, so indices wrap modulo depth.
  - With BRAM_EN = 0: no access, and BRAM_RDDATA holds.
  - done sampled high -> DUMP. done is ignored in every other state.
- Outside RUN: BRAM writes are dropped and BRAM_RDDATA holds its last value.
- DUMP:
  - Streams mem[RES_BASE .. RES_BASE+RES_LEN-1]; indices wrap modulo depth.
  - Internal read is pipelined with a prefetch/skid register so that consecutive words go out back-to-back while m_ready = 1.
  - m_data and m_last are stable whenever m_valid & !m_ready.
  - m_last = 1 only on the RES_LEN-th word.
  - A handshake on the last word -> IDLE; m_valid drops the next cycle.
- busy is derived as state != IDLE. It is registered with the state, so no glitch.
- Reset mid-operation returns immediately to IDLE with all outputs at reset values. A partially streamed dump is abandoned.

Test Plan:
- Load 4 words 0x11,0x22,0x33,0x44 (s_last on 4th), done tied 0 -> start high exactly one cycle, the cycle after the 4th beat; busy = 1; FSM stays in RUN.
- In RUN, drive BRAM_ADDR=0x8, BRAM_EN=1 -> BRAM_RDDATA = 0x33 one edge later. BRAM_EN=0 on the following cycles -> value holds.
- In RUN, write 0xAABBCCDD to addr 0x4 with BRAM_WE=4'b0101, then read addr 0x4 -> 0x00BB00DD (loaded 0x22 had upper bytes 0; byte0 = DD, byte2 = BB).
- RES_BASE=0, RES_LEN=4; assert done; hold m_ready low 3 cycles, then toggle 1/0 -> words 0x11, 0xAABBCCDD-merged word, 0x33, 0x44 delivered in order. m_data is stable while stalled; m_last only with 0x44; state returns to IDLE (busy=0).
- MEM_AW=2: stream 5 words without s_last, then a 6th with s_last -> err=1; start pulses once; mem holds the first 4 words.
- Assert aresetn low during DUMP after 2 words -> m_valid, start, busy, s_ready = 0 within the same cycle. After release, a new load is accepted from word 0.

Source files
------------

// File: rtl/pe_mem_bridge.sv
// pe_mem_bridge: word memory that loads a job from a host stream, serves
// pe_con BRAM traffic while the job runs, then streams the result region out.
module pe_mem_bridge #(
  parameter int MEM_AW   = 10,
  parameter int RES_BASE = 0,
  parameter int RES_LEN  = 64
) (
  input  logic        aclk,
  input  logic        aresetn,
  output logic        start,
  input  logic        done,
  input  logic [31:0] BRAM_ADDR,
  input  logic [31:0] BRAM_WRDATA,
  input  logic [3:0]  BRAM_WE,
  input  logic        BRAM_EN,
  output logic [31:0] BRAM_RDDATA,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [31:0] s_data,
  input  logic        s_last,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [31:0] m_data,
  output logic        m_last,
  output logic        busy,
  output logic        err
);

  localparam int DEPTH = 1 << MEM_AW;
  localparam logic [MEM_AW-1:0] BASE = MEM_AW'(RES_BASE);
  localparam logic [MEM_AW:0]   LEN  = (MEM_AW+1)'(RES_LEN);
  localparam logic [MEM_AW:0]   LAST = (MEM_AW+1)'(RES_LEN - 1);

  typedef enum logic [2:0] {
    IDLE, LOAD, START, RUN, DUMP
  } state_e;

  state_e state_q, state_d;

  logic [31:0] mem [DEPTH];

  logic [MEM_AW:0] ptr_q, ptr_d;
  logic [MEM_AW:0] cnt_q, cnt_d;
  logic            err_q, err_d;
  logic            start_q, s_ready_q, busy_q;
  logic            m_valid_q, m_valid_d;
  logic            m_last_q, m_last_d;
  logic [31:0]     m_data_q, m_data_d;
  logic [31:0]     rd_q, rd_d;

  logic              s_beat, m_beat, ld;
  logic              we;
  logic [3:0]        wbe;
  logic [MEM_AW-1:0] waddr, bidx, didx;
  logic [31:0]       wdata;
  logic              unused_addr;

  assign s_beat = s_valid & s_ready_q;
  assign m_beat = m_valid_q & m_ready;
  assign bidx   = BRAM_ADDR[MEM_AW+1:2];
  assign didx   = BASE + cnt_q[MEM_AW-1:0];

  assign unused_addr = ^{BRAM_ADDR[31:MEM_AW+2], BRAM_ADDR[1:0]};

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    m_valid_d = m_valid_q;
    m_last_d  = m_last_q;
    m_data_d  = m_data_q;
    rd_d      = rd_q;
    we        = 1'b0;
    wbe       = 4'hf;
    waddr     = bidx;
    wdata     = s_data;
    ld        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (s_beat) begin
          we      = 1'b1;
          waddr   = '0;
          ptr_d   = (MEM_AW+1)'(1);
          state_d = s_last ? START : LOAD;
        end
      end
      LOAD: begin
        if (s_beat) begin
          // ptr at full depth: beat is swallowed and flagged
          if (ptr_q[MEM_AW]) begin
            err_d = 1'b1;
          end else begin
            we    = 1'b1;
            waddr = ptr_q[MEM_AW-1:0];
            ptr_d = ptr_q + 1'b1;
          end
          if (s_last) state_d = START;
        end
      end
      START: state_d = RUN;
      RUN: begin
        if (BRAM_EN) begin
          rd_d  = mem[bidx];
          we    = |BRAM_WE;
          wbe   = BRAM_WE;
          wdata = BRAM_WRDATA;
        end
        if (done) begin
          state_d = DUMP;
          cnt_d   = '0;
        end
      end
      DUMP: begin
        // output register doubles as prefetch: refill whenever empty or draining
        ld = (!m_valid_q || m_ready) && (cnt_q != LEN);
        if (ld) begin
          m_valid_d = 1'b1;
          m_data_d  = mem[didx];
          m_last_d  = (cnt_q == LAST);
          cnt_d     = cnt_q + 1'b1;
        end else if (m_beat) begin
          m_valid_d = 1'b0;
        end
        if (m_beat && m_last_q) begin
          state_d   = IDLE;
          m_valid_d = 1'b0;
          m_last_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (wbe[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      start_q   <= 1'b0;
      s_ready_q <= 1'b0;
      busy_q    <= 1'b0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      m_data_q  <= '0;
      rd_q      <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      start_q   <= (state_d == START);
      s_ready_q <= (state_d == IDLE) || (state_d == LOAD);
      busy_q    <= (state_d != IDLE);
      m_valid_q <= m_valid_d;
      m_last_q  <= m_last_d;
      m_data_q  <= m_data_d;
      rd_q      <= rd_d;
    end
  end

  assign start       = start_q;
  assign s_ready     = s_ready_q;
  assign busy        = busy_q;
  assign err         = err_q;
  assign m_valid     = m_valid_q;
  assign m_last      = m_last_q;
  assign m_data      = m_data_q;
  assign BRAM_RDDATA = rd_q;

endmodule
